// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS32 encodings and the W-stage register layout
package mips_pkg;
  localparam int DW   = 32;
  localparam int RA_W = 5;
  typedef enum logic [2:0] {
    LOAD_LW  = 3'd0,
    LOAD_LB  = 3'd1,
    LOAD_LBU = 3'd2,
    LOAD_LH  = 3'd3,
    LOAD_LHU = 3'd4
  } load_type_e;
  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_to_reg;
    logic [2:0]      load_type;
    logic [1:0]      addr_lo;
    logic [RA_W-1:0] wa;
    logic [DW-1:0]   alu;
    logic [DW-1:0]   pc;
  } w_regs_t;
endpackage

// File: rtl/load_extend.sv
// load_extend: little-endian byte/half/word select with sign or zero extension
//   rdata     in  32  SRAM word
//   addr_lo   in  2   byte address bits [1:0]
//   load_type in  3   mips_pkg load encoding
//   ext_data  out 32  value written back to the register file
module load_extend
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  output logic [31:0] ext_data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    ext_data = load_type == LOAD_LB  ? {{24{b[7]}}, b} :
               load_type == LOAD_LBU ? {24'd0, b} :
               load_type == LOAD_LH  ? {{16{h[15]}}, h} :
               load_type == LOAD_LHU ? {16'd0, h} : rdata;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB pipeline register, SRAM read-data hold buffer and load writeback
//   clk, rst(async, active-low), stallW, flushW            control
//   validM, reg_writeM, mem_to_regM, load_typeM, addr_loM,
//   waM, alu_outM, pcM                                     MEM-stage results
//   data_rdata                                              SRAM word, valid while the load sits in W
//   we3, wa3, wd3                                           register file write port
//   validW, pcW                                             W-stage view for forwarding/trace
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DW   = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallW,
  input  logic            flushW,
  input  logic            validM,
  input  logic            reg_writeM,
  input  logic            mem_to_regM,
  input  logic [2:0]      load_typeM,
  input  logic [1:0]      addr_loM,
  input  logic [RA_W-1:0] waM,
  input  logic [DW-1:0]   alu_outM,
  input  logic [DW-1:0]   pcM,
  input  logic [DW-1:0]   data_rdata,
  output logic            we3,
  output logic [RA_W-1:0] wa3,
  output logic [DW-1:0]   wd3,
  output logic            validW,
  output logic [DW-1:0]   pcW
);
  w_regs_t       w_q, w_d;
  logic          hold_valid_q, hold_valid_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic [DW-1:0] ext_data;
  always_comb begin
    w_d = flushW ? '0 :
          stallW ? w_q :
          {validM, reg_writeM, mem_to_regM, load_typeM, addr_loM, waM, alu_outM, pcM};
    // The SRAM only presents the word for one cycle, so a stalled load keeps the first one it saw.
    hold_valid_d = !flushW && stallW && (hold_valid_q || (w_q.valid && w_q.mem_to_reg));
    hold_data_d  = hold_valid_d && !hold_valid_q ? data_rdata : hold_data_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      w_q          <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      w_q          <= w_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  load_extend u_ext (
    .rdata     (hold_valid_q ? hold_data_q : data_rdata),
    .addr_lo   (w_q.addr_lo),
    .load_type (w_q.load_type),
    .ext_data  (ext_data)
  );
  assign wd3    = w_q.mem_to_reg ? ext_data : w_q.alu;
  assign we3    = w_q.valid && w_q.reg_write && w_q.wa != '0;
  assign wa3    = w_q.wa;
  assign validW = w_q.valid;
  assign pcW    = w_q.pc;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: table-driven writeback checks plus stall/flush/reset sequences
module tb_mem_wb_stage;
  import mips_pkg::*;
  typedef struct {
    logic        vm, rw, m2r;
    logic [2:0]  lt;
    logic [1:0]  al;
    logic [4:0]  wa;
    logic [31:0] alu, rd, pc;
    logic        ewe;
    logic [31:0] ewd;
  } vec_t;
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        v;
    logic [31:0] pc;
  } exp_t;
  logic        clk = 1'b0, rst = 1'b0, stallW = 1'b0, flushW = 1'b0;
  logic        validM = 1'b0, reg_writeM = 1'b0, mem_to_regM = 1'b0;
  logic [2:0]  load_typeM = 3'd0;
  logic [1:0]  addr_loM = 2'd0;
  logic [4:0]  waM = 5'd0;
  logic [31:0] alu_outM = 32'd0, pcM = 32'd0, data_rdata = 32'd0;
  logic        we3, validW;
  logic [4:0]  wa3;
  logic [31:0] wd3, pcW;
  int pass_cnt = 0, total = 0;
  vec_t vecs[$];
  exp_t sb[$];
  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW), .validM(validM),
    .reg_writeM(reg_writeM), .mem_to_regM(mem_to_regM), .load_typeM(load_typeM),
    .addr_loM(addr_loM), .waM(waM), .alu_outM(alu_outM), .pcM(pcM),
    .data_rdata(data_rdata), .we3(we3), .wa3(wa3), .wd3(wd3), .validW(validW), .pcW(pcW)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", n, act, exp);
  endtask
  function automatic vec_t mk(input logic vm, rw, m2r, input logic [2:0] lt, input logic [1:0] al,
                              input logic [4:0] wa, input logic [31:0] alu, rd,
                              input logic ewe, input logic [31:0] ewd);
    vec_t v;
    v.vm = vm; v.rw = rw; v.m2r = m2r; v.lt = lt; v.al = al; v.wa = wa;
    v.alu = alu; v.rd = rd; v.pc = 32'd0; v.ewe = ewe; v.ewd = ewd;
    return v;
  endfunction
  task automatic drive_m(input vec_t v);
    validM = v.vm; reg_writeM = v.rw; mem_to_regM = v.m2r; load_typeM = v.lt;
    addr_loM = v.al; waM = v.wa; alu_outM = v.alu; pcM = v.pc;
  endtask
  task automatic chk_zero(input string n);
    chk({n, " we3"}, 32'(we3), 32'd0);
    chk({n, " wa3"}, 32'(wa3), 32'd0);
    chk({n, " wd3"}, wd3, 32'd0);
    chk({n, " validW"}, 32'(validW), 32'd0);
    chk({n, " pcW"}, pcW, 32'd0);
  endtask
  task automatic rand_in();
    validM = 1'($urandom); reg_writeM = 1'($urandom); mem_to_regM = 1'($urandom);
    load_typeM = 3'($urandom_range(4)); addr_loM = 2'($urandom); waM = 5'($urandom);
    alu_outM = $urandom; pcM = $urandom; data_rdata = $urandom;
    stallW = 1'($urandom); flushW = 1'($urandom);
  endtask
  task automatic load_w(input logic [4:0] wa, input logic [31:0] pc);
    @(negedge clk);
    validM = 1'b1; reg_writeM = 1'b1; mem_to_regM = 1'b1; load_typeM = LOAD_LW;
    addr_loM = 2'd0; waM = wa; alu_outM = 32'h0BAD_0BAD; pcM = pc;
  endtask
  initial begin
    exp_t e;
    vec_t v;
    vecs.push_back(mk(1, 1, 1, LOAD_LB,  2'b11, 5'd5,  32'hAAAA_AAAA, 32'h80FF_0000, 1, 32'hFFFF_FF80));
    vecs.push_back(mk(1, 1, 1, LOAD_LBU, 2'b11, 5'd5,  32'hAAAA_AAAA, 32'h80FF_0000, 1, 32'h0000_0080));
    vecs.push_back(mk(1, 1, 1, LOAD_LH,  2'b10, 5'd6,  32'hAAAA_AAAA, 32'h8001_1234, 1, 32'hFFFF_8001));
    vecs.push_back(mk(1, 1, 1, LOAD_LHU, 2'b10, 5'd6,  32'hAAAA_AAAA, 32'h8001_1234, 1, 32'h0000_8001));
    vecs.push_back(mk(1, 1, 1, LOAD_LW,  2'b00, 5'd7,  32'hAAAA_AAAA, 32'h8001_1234, 1, 32'h8001_1234));
    vecs.push_back(mk(1, 1, 1, LOAD_LB,  2'b00, 5'd8,  32'hAAAA_AAAA, 32'h8001_1234, 1, 32'h0000_0034));
    vecs.push_back(mk(1, 1, 1, LOAD_LB,  2'b01, 5'd8,  32'hAAAA_AAAA, 32'h8001_1234, 1, 32'h0000_0012));
    vecs.push_back(mk(1, 1, 1, LOAD_LB,  2'b10, 5'd8,  32'hAAAA_AAAA, 32'h8001_1234, 1, 32'h0000_0001));
    vecs.push_back(mk(1, 1, 1, LOAD_LH,  2'b00, 5'd8,  32'hAAAA_AAAA, 32'h8001_9234, 1, 32'hFFFF_9234));
    vecs.push_back(mk(1, 1, 1, LOAD_LB,  2'b01, 5'd10, 32'hAAAA_AAAA, 32'h0000_F000, 1, 32'hFFFF_FFF0));
    vecs.push_back(mk(1, 1, 1, LOAD_LBU, 2'b01, 5'd10, 32'hAAAA_AAAA, 32'h0000_F000, 1, 32'h0000_00F0));
    vecs.push_back(mk(1, 1, 0, LOAD_LW,  2'b00, 5'd0,  32'h0000_002A, 32'h5555_5555, 0, 32'h0000_002A));
    vecs.push_back(mk(1, 1, 0, LOAD_LW,  2'b00, 5'd9,  32'h0000_002A, 32'h5555_5555, 1, 32'h0000_002A));
    vecs.push_back(mk(0, 1, 0, LOAD_LW,  2'b00, 5'd9,  32'h0000_0077, 32'h5555_5555, 0, 32'h0000_0077));
    vecs.push_back(mk(1, 0, 0, LOAD_LW,  2'b00, 5'd3,  32'h1357_9BDF, 32'h5555_5555, 0, 32'h1357_9BDF));
    // reset held with random inputs
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 rand_in(); #1 chk_zero($sformatf("reset%0d", k));
    end
    @(negedge clk);
    stallW = 0; flushW = 0; validM = 0; rst = 1'b1;
    foreach (vecs[i]) begin
      v = vecs[i];
      v.pc = 32'h0040_0000 + 32'(i) * 4;
      @(negedge clk); drive_m(v);
      sb.push_back('{we: v.ewe, wa: v.wa, wd: v.ewd, v: v.vm, pc: v.pc});
      @(posedge clk); #1 data_rdata = v.rd; #1;
      if (sb.size() == 0) chk($sformatf("vec%0d scoreboard", i), 32'd0, 32'd1);
      else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d we3", i), 32'(we3), 32'(e.we));
        chk($sformatf("vec%0d wa3", i), 32'(wa3), 32'(e.wa));
        chk($sformatf("vec%0d wd3", i), wd3, e.wd);
        chk($sformatf("vec%0d validW", i), 32'(validW), 32'(e.v));
        chk($sformatf("vec%0d pcW", i), pcW, e.pc);
      end
    end
    // load held across a 3-cycle stall while SRAM data moves on
    load_w(5'd7, 32'h500);
    @(posedge clk); #1 data_rdata = 32'h1234_5678; stallW = 1;
    mem_to_regM = 0; waM = 5'd11; alu_outM = 32'h55; pcM = 32'h504; #1;
    chk("stall0 wd3", wd3, 32'h1234_5678);
    chk("stall0 we3", 32'(we3), 32'd1);
    chk("stall0 wa3", 32'(wa3), 32'd7);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1 data_rdata = 32'hDEAD_BEEF; #1;
      chk($sformatf("stall%0d wd3", k), wd3, 32'h1234_5678);
      chk($sformatf("stall%0d pcW", k), pcW, 32'h500);
      chk($sformatf("stall%0d hold", k), 32'(dut.hold_valid_q), 32'd1);
    end
    stallW = 0; #1;
    chk("release wd3", wd3, 32'h1234_5678);
    @(posedge clk); #2;
    chk("after wd3", wd3, 32'h55);
    chk("after wa3", 32'(wa3), 32'd11);
    chk("after hold", 32'(dut.hold_valid_q), 32'd0);
    // flush wins over stall, and drops a held word
    load_w(5'd8, 32'h600);
    @(posedge clk); #1 data_rdata = 32'hCAFE_0001; stallW = 1; load_typeM = LOAD_LH; waM = 5'd9; pcM = 32'h604;
    @(posedge clk); #1;
    chk("preflush hold", 32'(dut.hold_valid_q), 32'd1);
    chk("preflush wd3", wd3, 32'hCAFE_0001);
    flushW = 1;
    @(posedge clk); #1 flushW = 0; stallW = 0; validM = 0; #1;
    chk("flush hold", 32'(dut.hold_valid_q), 32'd0);
    chk_zero("flush");
    // asynchronous reset in the middle of a stall
    load_w(5'd12, 32'h700);
    @(posedge clk); #1 data_rdata = 32'h0F0F_0F0F; stallW = 1;
    @(posedge clk); #1;
    chk("prerst we3", 32'(we3), 32'd1);
    #2 rst = 1'b0; #1;
    chk_zero("midrst");
    chk("midrst hold", 32'(dut.hold_valid_q), 32'd0);
    validM = 0; stallW = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("postrst we3", 32'(we3), 32'd0);
    chk("postrst validW", 32'(validW), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
